// File: rtl/spi_ram_bridge_if.sv
// SPI pin bundle for spi_ram_bridge: the board-side serial lines plus the status outputs.
// The master modport is the board/bench side, the slave modport is the bridge.
interface spi_ram_bridge_if;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic busy;
  logic frame_abort;

  modport slave  (input SS_n, MOSI, output MISO, busy, frame_abort);
  modport master (output SS_n, MOSI, input MISO, busy, frame_abort);
endinterface

// File: rtl/spi_ram_bridge.sv
// SPI slave fronting a flop-array RAM with auto-incrementing read/write address registers.
// Define SPI_BURST_EN to allow back-to-back data words inside one SS_n assertion.
module spi_ram_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_ram_bridge_if.slave spi
);

  localparam int DEPTH   = 2 ** ADDR_WIDTH;
  localparam int SHIFT_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W   = $clog2(SHIFT_W + 1);

  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]      DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]      DATA_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_TA, RD_SHIFT, DONE
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    cmd_bit;
  logic [SHIFT_W-2:0]      rx_shift;
  logic [DATA_WIDTH-2:0]   tx_shift;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    miso_q;
  logic                    busy_q;
  logic                    abort_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [SHIFT_W-1:0]      rx_next;
  logic                    mem_we;
  logic                    mid_frame;

  assign rx_next = {rx_shift, spi.MOSI};
  assign rd_word = mem[rd_addr];

  // Gating with rst_n keeps a write from landing on the same edge reset is asserted.
  assign mem_we = rst_n && !spi.SS_n && (state == WR_DATA) && (bit_cnt == DATA_LAST);

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[wr_addr] <= rx_next[DATA_WIDTH-1:0];
  end

  // In burst mode a word boundary (counter parked at DATA_FULL) is a clean place to stop.
  always_comb begin
    mid_frame = (state != IDLE) && (state != DONE);
`ifdef SPI_BURST_EN
    if ((state == WR_DATA || state == RD_SHIFT) && bit_cnt == DATA_FULL)
      mid_frame = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      cmd_bit  <= 1'b0;
      rx_shift <= '0;
      tx_shift <= '0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      miso_q   <= 1'b0;
      busy_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      miso_q  <= 1'b0;
      if (spi.SS_n) begin
        state    <= IDLE;
        busy_q   <= 1'b0;
        bit_cnt  <= '0;
        cmd_bit  <= 1'b0;
        rx_shift <= '0;
        tx_shift <= '0;
        abort_q  <= mid_frame;
      end else begin
        busy_q   <= 1'b1;
        rx_shift <= rx_next[SHIFT_W-2:0];
        case (state)
          IDLE: begin
            cmd_bit <= spi.MOSI;
            bit_cnt <= '0;
            state   <= CMD;
          end
          CMD: begin
            bit_cnt <= '0;
            case ({cmd_bit, spi.MOSI})
              2'b00:   state <= WR_ADDR;
              2'b01:   state <= WR_DATA;
              2'b10:   state <= RD_ADDR;
              default: state <= RD_TA;
            endcase
          end
          WR_ADDR: begin
            if (bit_cnt == ADDR_LAST) begin
              wr_addr <= rx_next[ADDR_WIDTH-1:0];
              state   <= DONE;
            end else begin
              bit_cnt <= bit_cnt + CNT_ONE;
            end
          end
          RD_ADDR: begin
            if (bit_cnt == ADDR_LAST) begin
              rd_addr <= rx_next[ADDR_WIDTH-1:0];
              state   <= DONE;
            end else begin
              bit_cnt <= bit_cnt + CNT_ONE;
            end
          end
          WR_DATA: begin
            if (bit_cnt == DATA_LAST) begin
              wr_addr <= wr_addr + ADDR_ONE;
`ifdef SPI_BURST_EN
              bit_cnt <= DATA_FULL;
`else
              state   <= DONE;
`endif
            end else if (bit_cnt == DATA_FULL) begin
              bit_cnt <= CNT_ONE;
            end else begin
              bit_cnt <= bit_cnt + CNT_ONE;
            end
          end
          RD_TA: begin
            tx_shift <= rd_word[DATA_WIDTH-2:0];
            miso_q   <= rd_word[DATA_WIDTH-1];
            rd_addr  <= rd_addr + ADDR_ONE;
            bit_cnt  <= CNT_ONE;
            state    <= RD_SHIFT;
          end
          RD_SHIFT: begin
            // DATA_FULL means the previous word is fully out; fetch the next one with no gap.
            if (bit_cnt == DATA_FULL) begin
              tx_shift <= rd_word[DATA_WIDTH-2:0];
              miso_q   <= rd_word[DATA_WIDTH-1];
              rd_addr  <= rd_addr + ADDR_ONE;
              bit_cnt  <= CNT_ONE;
            end else begin
              miso_q   <= tx_shift[DATA_WIDTH-2];
              tx_shift <= tx_shift << 1;
              bit_cnt  <= bit_cnt + CNT_ONE;
`ifndef SPI_BURST_EN
              if (bit_cnt == DATA_LAST)
                state <= DONE;
`endif
            end
          end
          DONE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign spi.MISO        = miso_q;
  assign spi.busy        = busy_q;
  assign spi.frame_abort = abort_q;

endmodule
